control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 tb/tb_control_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the datapath.
// Walks fetch (T0..T2) and per-opcode execute states (T3..T6), emitting
// one cycle of Moore control strobes per state from the state and IR fields.
module control_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic [31:0]     IR,
    input  logic            Stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            MDRout,
    output logic            MARin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            lowin,
    output logic            highin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPC,
    output logic            Read,
    output logic [3:0]      CONTROL,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            Run,
    output logic            Illegal
);

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t state, next_state;

    logic [OPW-1:0] op;
    logic [3:0]     ra, rb, rc;
    logic           is_alu, is_muldiv, is_unary, is_halt, is_legal;
    logic [3:0]     ctrl_code;
    state_t         boundary_next;

    // Only the opcode and three register fields steer control; the low
    // immediate bits belong to the datapath and are deliberately ignored.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    assign op = IR[31 -: OPW];
    assign ra = IR[26:23];
    assign rb = IR[22:19];
    assign rc = IR[18:15];

    // One-hot register select; field values beyond NREG shift out to none.
    function automatic logic [NREG-1:0] one_hot(input logic [3:0] field);
        return {{(NREG-1){1'b0}}, 1'b1} << field;
    endfunction

    // Classify the opcode into its execute shape and pick the ALU code.
    always_comb begin
        is_alu    = 1'b0;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        is_halt   = 1'b0;
        is_legal  = 1'b1;
        ctrl_code = 4'd0;
        case (op)
            OP_AND:  begin is_alu = 1'b1;    ctrl_code = 4'd0;  end
            OP_OR:   begin is_alu = 1'b1;    ctrl_code = 4'd1;  end
            OP_ADD:  begin is_alu = 1'b1;    ctrl_code = 4'd2;  end
            OP_SUB:  begin is_alu = 1'b1;    ctrl_code = 4'd3;  end
            OP_SHR:  begin is_alu = 1'b1;    ctrl_code = 4'd4;  end
            OP_SHL:  begin is_alu = 1'b1;    ctrl_code = 4'd5;  end
            OP_ROR:  begin is_alu = 1'b1;    ctrl_code = 4'd6;  end
            OP_ROL:  begin is_alu = 1'b1;    ctrl_code = 4'd7;  end
            OP_MUL:  begin is_muldiv = 1'b1; ctrl_code = 4'd8;  end
            OP_DIV:  begin is_muldiv = 1'b1; ctrl_code = 4'd9;  end
            OP_NEG:  begin is_unary = 1'b1;  ctrl_code = 4'd10; end
            OP_NOT:  begin is_unary = 1'b1;  ctrl_code = 4'd11; end
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    // State register; Clear wins over everything, even mid-instruction.
    always_ff @(posedge Clock) begin
        if (Clear) state <= RESET;
        else       state <= next_state;
    end

    // Sequence through the states; Stop is only honoured at an instruction's last state.
    always_comb begin
        boundary_next = Stop ? HALT : T0;
        next_state    = state;
        case (state)
            RESET: next_state = T0;
            T0:    next_state = T1;
            T1:    next_state = T2;
            T2:    next_state = T3;
            T3: begin
                if (is_alu || is_muldiv || is_unary) next_state = T4;
                else if (is_halt)                    next_state = HALT;
                else                                 next_state = boundary_next;
            end
            T4:    next_state = is_unary ? boundary_next : T5;
            T5:    next_state = is_muldiv ? T6 : boundary_next;
            T6:    next_state = boundary_next;
            HALT:  next_state = HALT;
            default: next_state = RESET;
        endcase
    end

    // Moore strobes for the current step; at most one bus driver per state.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; lowin = 1'b0;
        highin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; CONTROL = 4'd0;
        Rout = '0; Rin = '0; Illegal = 1'b0;
        Run = (state != RESET) && (state != HALT);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_alu || is_muldiv) begin
                    Rout = one_hot(rb);
                    Yin  = 1'b1;
                end else if (is_unary) begin
                    Rout    = one_hot(rb);
                    CONTROL = ctrl_code;
                    Zlowin  = 1'b1;
                end
                Illegal = !is_legal;
            end
            T4: begin
                if (is_alu || is_muldiv) begin
                    Rout    = one_hot(rc);
                    CONTROL = ctrl_code;
                    Zlowin  = 1'b1;
                    Zhighin = is_muldiv;
                end else if (is_unary) begin
                    Zlowout = 1'b1;
                    Rin     = one_hot(ra);
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) lowin = 1'b1;
                else           Rin   = one_hot(ra);
            end
            T6: begin Zhighout = 1'b1; highin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed walk through fetch, each execute shape,
// illegal opcode, HALT, mid-instruction Clear and Stop at the boundary.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Stop;
    logic [31:0] IR;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zlowin, Zhighin;
    logic        lowin, highin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic [3:0]  CONTROL;
    logic [15:0] Rout, Rin;
    logic        Run, Illegal;

    int test_count = 0;
    int fail_count = 0;

    // Strobe bit positions inside the packed 15-bit strobe group.
    localparam logic [14:0] S_PCOUT    = 15'h4000;
    localparam logic [14:0] S_ZLOWOUT  = 15'h2000;
    localparam logic [14:0] S_ZHIGHOUT = 15'h1000;
    localparam logic [14:0] S_MDROUT   = 15'h0800;
    localparam logic [14:0] S_MARIN    = 15'h0400;
    localparam logic [14:0] S_ZLOWIN   = 15'h0200;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0100;
    localparam logic [14:0] S_LOWIN    = 15'h0080;
    localparam logic [14:0] S_HIGHIN   = 15'h0040;
    localparam logic [14:0] S_PCIN     = 15'h0020;
    localparam logic [14:0] S_MDRIN    = 15'h0010;
    localparam logic [14:0] S_IRIN     = 15'h0008;
    localparam logic [14:0] S_YIN      = 15'h0004;
    localparam logic [14:0] S_INCPC    = 15'h0002;
    localparam logic [14:0] S_READ     = 15'h0001;

    localparam logic [31:0] IR_AND  = 32'h4A920000;
    localparam logic [31:0] IR_MUL  = 32'h78188000;
    localparam logic [31:0] IR_NOT  = 32'h93B00000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_ADD  = 32'h18918000;

    logic [52:0] observed;
    assign observed = {PCout, Zlowout, Zhighout, MDRout, MARin, Zlowin, Zhighin,
                       lowin, highin, PCin, MDRin, IRin, Yin, IncPC, Read,
                       CONTROL, Rout, Rin, Run, Illegal};

    control_sequencer #(.NREG(16), .OPW(5)) dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zlowin(Zlowin), .Zhighin(Zhighin), .lowin(lowin),
        .highin(highin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL), .Rout(Rout), .Rin(Rin),
        .Run(Run), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    function automatic logic [52:0] ex(input logic [14:0] s, input logic [3:0] c,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic run, input logic ill);
        return {s, c, ro, ri, run, ill};
    endfunction

    task automatic apply_stimulus(input logic clr, input logic stp, input logic [31:0] ir);
        Clear = clr;
        Stop  = stp;
        IR    = ir;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [52:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks T0 (already entered), then T1 and T2 of the fetch.
    task automatic check_fetch(input string tag);
        check_output({tag, "_T0"}, ex(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        check_output({tag, "_T1"}, ex(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        check_output({tag, "_T2"}, ex(S_MDROUT | S_IRIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
    endtask

    localparam logic [52:0] ALL_ZERO = 53'h0;

    initial begin
        // Reset held two cycles
        apply_stimulus(1'b1, 1'b0, 32'h0);
        tick(); tick();
        check_output("reset", ALL_ZERO);

        // AND R5,R2,R4
        apply_stimulus(1'b0, 1'b0, IR_AND);
        tick();
        check_fetch("and");
        check_output("and_T3", ex(S_YIN, 4'd0, 16'h0004, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("and_T4", ex(S_ZLOWIN, 4'd0, 16'h0010, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("and_T5", ex(S_ZLOWOUT, 4'd0, 16'h0, 16'h0020, 1'b1, 1'b0));
        tick();

        // MUL R3,R1
        apply_stimulus(1'b0, 1'b0, IR_MUL);
        check_fetch("mul");
        check_output("mul_T3", ex(S_YIN, 4'd0, 16'h0008, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("mul_T4", ex(S_ZLOWIN | S_ZHIGHIN, 4'd8, 16'h0002, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("mul_T5", ex(S_ZLOWOUT | S_LOWIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("mul_T6", ex(S_ZHIGHOUT | S_HIGHIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();

        // NOT R7,R6
        apply_stimulus(1'b0, 1'b0, IR_NOT);
        check_fetch("not");
        check_output("not_T3", ex(S_ZLOWIN, 4'd11, 16'h0040, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("not_T4", ex(S_ZLOWOUT, 4'd0, 16'h0, 16'h0080, 1'b1, 1'b0));
        tick();

        // Unknown opcode then HALT
        apply_stimulus(1'b0, 1'b0, IR_BAD);
        check_fetch("bad");
        check_output("bad_T3", ex(15'h0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b1));
        tick();
        apply_stimulus(1'b0, 1'b0, IR_HALT);
        check_fetch("halt");
        check_output("halt_T3", ex(15'h0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        for (int i = 0; i < 20; i++) begin
            tick();
            check_output($sformatf("halted_%0d", i), ALL_ZERO);
        end

        // Clear pulsed during T4 of AND
        apply_stimulus(1'b1, 1'b0, IR_AND);
        tick();
        check_output("clr_reset", ALL_ZERO);
        apply_stimulus(1'b0, 1'b0, IR_AND);
        tick();
        check_fetch("clr_and");
        check_output("clr_and_T3", ex(S_YIN, 4'd0, 16'h0004, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("clr_and_T4", ex(S_ZLOWIN, 4'd0, 16'h0010, 16'h0, 1'b1, 1'b0));
        apply_stimulus(1'b1, 1'b0, IR_AND);
        tick();
        check_output("clr_midinst", ALL_ZERO);
        apply_stimulus(1'b0, 1'b0, IR_AND);
        tick();
        check_output("clr_restart_T0", ex(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));

        // Stop during ADD R1,R2,R3 is deferred to the boundary
        apply_stimulus(1'b0, 1'b0, IR_ADD);
        check_fetch("add");
        check_output("add_T3", ex(S_YIN, 4'd0, 16'h0004, 16'h0, 1'b1, 1'b0));
        apply_stimulus(1'b0, 1'b1, IR_ADD);
        tick();
        check_output("add_T4", ex(S_ZLOWIN, 4'd2, 16'h0008, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("add_T5", ex(S_ZLOWOUT, 4'd0, 16'h0, 16'h0002, 1'b1, 1'b0));
        tick();
        check_output("add_halted", ALL_ZERO);
        tick();
        check_output("add_halted2", ALL_ZERO);

        // Stop pulsed only in T0 has no effect
        apply_stimulus(1'b1, 1'b0, IR_NOP);
        tick();
        apply_stimulus(1'b0, 1'b0, IR_NOP);
        tick();
        apply_stimulus(1'b0, 1'b1, IR_NOP);
        check_output("stop_T0", ex(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        apply_stimulus(1'b0, 1'b0, IR_NOP);
        check_output("stop_T1", ex(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        tick();
        check_output("nop_T3", ex(15'h0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        tick();
        check_output("nop_next_T0", ex(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
